// File: rtl/synth_voice_pkg.sv
// Shared types and widths for the synth voice allocator.
// FSM states plus the MIDI key/velocity field widths.
package synth_voice_pkg;

  localparam int KEY_W         = 7;
  localparam int VEL_W         = 8;
  localparam int AGE_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SETUP,
    STROBE,
    OFFREL
  } state_t;

endpackage

// File: rtl/voice_allocator_voice_select.sv
// Folds one voice into the running match/free/oldest candidates; purely combinational.
// Latency: 0 cycles; no backpressure, the caller steps one voice per cycle.
module voice_select
  import synth_voice_pkg::*;
#(
  parameter int V_WIDTH = 3,
  parameter int AGE_W   = AGE_W_DEFAULT
) (
  input  logic [V_WIDTH-1:0] idx,
  input  logic               active,
  input  logic [KEY_W-1:0]   key,
  input  logic [AGE_W-1:0]   age,
  input  logic [KEY_W-1:0]   want_key,
  input  logic               cur_match_fnd,
  input  logic [V_WIDTH-1:0] cur_match_idx,
  input  logic               cur_free_fnd,
  input  logic [V_WIDTH-1:0] cur_free_idx,
  input  logic               cur_old_fnd,
  input  logic [V_WIDTH-1:0] cur_old_idx,
  input  logic [AGE_W-1:0]   cur_old_age,
  output logic               nxt_match_fnd,
  output logic [V_WIDTH-1:0] nxt_match_idx,
  output logic               nxt_free_fnd,
  output logic [V_WIDTH-1:0] nxt_free_idx,
  output logic               nxt_old_fnd,
  output logic [V_WIDTH-1:0] nxt_old_idx,
  output logic [AGE_W-1:0]   nxt_old_age
);

  always_comb begin
    nxt_match_fnd = cur_match_fnd;
    nxt_match_idx = cur_match_idx;
    nxt_free_fnd  = cur_free_fnd;
    nxt_free_idx  = cur_free_idx;
    nxt_old_fnd   = cur_old_fnd;
    nxt_old_idx   = cur_old_idx;
    nxt_old_age   = cur_old_age;

    // Voices arrive in ascending order, so first-found means lowest index.
    if (active && (key == want_key) && !cur_match_fnd) begin
      nxt_match_fnd = 1'b1;
      nxt_match_idx = idx;
    end

    if (!active && !cur_free_fnd) begin
      nxt_free_fnd = 1'b1;
      nxt_free_idx = idx;
    end

    // Strict compare keeps the earlier (lower) index on equal ages.
    if (active && (!cur_old_fnd || (age > cur_old_age))) begin
      nxt_old_fnd = 1'b1;
      nxt_old_idx = idx;
      nxt_old_age = age;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Assigns note-on events to voices (retrigger, free, steal oldest) and releases voices on note-off.
// Latency: note-on strobe VOICES+2 cycles after accept; req_ready only in IDLE, so one event in flight.
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3,
  parameter int AGE_W   = AGE_W_DEFAULT
) (
  input  logic               sCLK_XVXENVS,
  input  logic               reset_reg,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_is_on,
  input  logic [KEY_W-1:0]   req_key,
  input  logic [VEL_W-1:0]   req_vel,
  input  logic               all_off,
  output logic               reg_note_on,
  output logic [V_WIDTH-1:0] reg_cur_key_adr,
  output logic [VEL_W-1:0]   reg_cur_vel_on,
  output logic               voice_off,
  output logic [V_WIDTH-1:0] voice_off_adr,
  output logic [VOICES-1:0]  voice_gate,
  output logic               stole
);

  localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);
  localparam logic [AGE_W-1:0]   AGE_MAX  = '1;

  state_t state, state_nxt;

  logic               ready_en;
  logic               accept;
  logic [V_WIDTH-1:0] scan_idx;

  logic               lat_on;
  logic [KEY_W-1:0]   lat_key;
  logic [VEL_W-1:0]   lat_vel;

  logic [KEY_W-1:0]   key_q [VOICES];
  logic [AGE_W-1:0]   age_q [VOICES];

  logic               match_fnd, free_fnd, old_fnd;
  logic [V_WIDTH-1:0] match_idx, free_idx, old_idx;
  logic [AGE_W-1:0]   old_age;

  logic               nxt_match_fnd, nxt_free_fnd, nxt_old_fnd;
  logic [V_WIDTH-1:0] nxt_match_idx, nxt_free_idx, nxt_old_idx;
  logic [AGE_W-1:0]   nxt_old_age;

  logic [V_WIDTH-1:0] target;
  logic               take_old;

  // ready_en holds req_ready low for the first cycle after reset is released.
  assign req_ready = ready_en && (state == IDLE) && !all_off;
  assign accept    = req_valid && req_ready;

  voice_select #(
    .V_WIDTH (V_WIDTH),
    .AGE_W   (AGE_W)
  ) u_select (
    .idx           (scan_idx),
    .active        (voice_gate[scan_idx]),
    .key           (key_q[scan_idx]),
    .age           (age_q[scan_idx]),
    .want_key      (lat_key),
    .cur_match_fnd (match_fnd),
    .cur_match_idx (match_idx),
    .cur_free_fnd  (free_fnd),
    .cur_free_idx  (free_idx),
    .cur_old_fnd   (old_fnd),
    .cur_old_idx   (old_idx),
    .cur_old_age   (old_age),
    .nxt_match_fnd (nxt_match_fnd),
    .nxt_match_idx (nxt_match_idx),
    .nxt_free_fnd  (nxt_free_fnd),
    .nxt_free_idx  (nxt_free_idx),
    .nxt_old_fnd   (nxt_old_fnd),
    .nxt_old_idx   (nxt_old_idx),
    .nxt_old_age   (nxt_old_age)
  );

  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset_reg) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take_old  = !match_fnd && !free_fnd;
    target    = match_fnd ? match_idx : (free_fnd ? free_idx : old_idx);
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (scan_idx == LAST_IDX) state_nxt = lat_on ? SETUP : OFFREL;
      SETUP:   state_nxt = STROBE;
      STROBE:  state_nxt = IDLE;
      OFFREL:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset_reg) begin
      ready_en        <= 1'b0;
      scan_idx        <= '0;
      lat_on          <= 1'b0;
      lat_key         <= '0;
      lat_vel         <= '0;
      match_fnd       <= 1'b0;
      match_idx       <= '0;
      free_fnd        <= 1'b0;
      free_idx        <= '0;
      old_fnd         <= 1'b0;
      old_idx         <= '0;
      old_age         <= '0;
      reg_note_on     <= 1'b0;
      reg_cur_key_adr <= '0;
      reg_cur_vel_on  <= '0;
      voice_off       <= 1'b0;
      voice_off_adr   <= '0;
      voice_gate      <= '0;
      stole           <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        key_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      ready_en    <= 1'b1;
      reg_note_on <= (state == STROBE);
      stole       <= (state == STROBE) && take_old;
      voice_off   <= 1'b0;

      case (state)
        IDLE: begin
          if (all_off) begin
            voice_gate <= '0;
          end else if (accept) begin
            lat_on    <= req_is_on;
            lat_key   <= req_key;
            lat_vel   <= req_vel;
            scan_idx  <= '0;
            match_fnd <= 1'b0;
            free_fnd  <= 1'b0;
            old_fnd   <= 1'b0;
            old_age   <= '0;
          end
        end

        SCAN: begin
          scan_idx  <= scan_idx + V_WIDTH'(1);
          match_fnd <= nxt_match_fnd;
          match_idx <= nxt_match_idx;
          free_fnd  <= nxt_free_fnd;
          free_idx  <= nxt_free_idx;
          old_fnd   <= nxt_old_fnd;
          old_idx   <= nxt_old_idx;
          old_age   <= nxt_old_age;
        end

        SETUP: begin
          reg_cur_key_adr <= target;
          reg_cur_vel_on  <= lat_vel;
          for (int i = 0; i < VOICES; i++) begin
            if (V_WIDTH'(i) == target) begin
              voice_gate[i] <= 1'b1;
              key_q[i]      <= lat_key;
              age_q[i]      <= '0;
            end else if (voice_gate[i] && (age_q[i] != AGE_MAX)) begin
              age_q[i] <= age_q[i] + AGE_W'(1);
            end
          end
        end

        OFFREL: begin
          // Key and age are left in place; only the gate drops.
          if (match_fnd) begin
            voice_gate[match_idx] <= 1'b0;
            voice_off             <= 1'b1;
            voice_off_adr         <= match_idx;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Sequencer that owns the per-voice note/velocity registers of the synth engine. Accepts note-on/note-off events from the MIDI front end and assigns each note-on to a voice: retrigger, free voice, or steal the oldest. It then drives the key-address, velocity and note-on strobe that load the per-voice velocity store. It also tracks per-voice gate state and issues note-off strobes to the envelope side.

Parameters:
VOICES, 8, number of synth voices (power of two)
V_WIDTH, 3, voice index width, log2(VOICES)
AGE_W, 8, per-voice age counter width

Ports:
sCLK_XVXENVS  in  1  engine clock; all logic on rising edge
reset_reg  in  1  synchronous, active-high reset
req_valid  in  1  event present
req_ready  out  1  allocator can accept an event
req_is_on  in  1  1 = note-on, 0 = note-off
req_key  in  7  MIDI key number
req_vel  in  8  MIDI velocity; ignored for note-off
all_off  in  1  clear every voice gate
reg_note_on  out  1  note-on strobe to velocity store
reg_cur_key_adr  out  V_WIDTH  target voice index
reg_cur_vel_on  out  8  velocity written to target voice
voice_off  out  1  one-cycle note-off strobe
voice_off_adr  out  V_WIDTH  voice released by voice_off
voice_gate  out  VOICES  per-voice active bit
stole  out  1  one-cycle pulse: last note-on stole an active voice

Behaviour:
- Reset: all outputs 0, including req_ready. Every voice is inactive with key 0 and age 0. FSM goes to IDLE. Reset mid-operation aborts the event in flight with no strobe.
- Per-voice state: active bit (drives voice_gate), key[6:0], age[AGE_W-1:0].
- FSM states: IDLE -> SCAN -> SETUP -> STROBE -> IDLE, plus OFFREL.
- IDLE:
  - req_ready = 1 only in IDLE with all_off = 0.
  - An event is accepted on req_valid & req_ready; key, vel and type are latched.
  - all_off = 1 in IDLE clears every active bit in one cycle and takes priority over a same-cycle request, which is not accepted. all_off in any other state is ignored.
- SCAN: one voice per cycle, index 0..VOICES-1, so VOICES cycles. Three candidates are tracked:
  - match: lowest-index active voice with key == latched key;
  - free: lowest-index inactive voice;
  - oldest: active voice with largest age; ties go to the lowest index.
- Note-on target: match if found, else free, else oldest. stole = 1 only when oldest is chosen.
- SETUP (1 cycle):
  - Register the target into reg_cur_key_adr and the velocity into reg_cur_vel_on.
  - Set the target active and its key to the latched key.
  - Set age[target] = 0; every other active voice increments its age, saturating at 2^AGE_W-1. Inactive ages are unchanged.
- STROBE (1 cycle): reg_note_on = 1 and stole pulses if applicable. Address and velocity stay stable in SETUP, STROBE and afterwards until the next SETUP, so downstream capture on the reg_note_on rising edge is safe.
- Note-on latency: accept edge to reg_note_on high = VOICES+2 cycles.
- Note-off: after SCAN, go to OFFREL for 1 cycle.
  - If a match exists: clear its active bit, voice_off = 1, voice_off_adr = match. Key and age are kept.
  - If there is no match: no pulse and no state change.
  - Then return to IDLE.
- Back-to-back events are allowed. Throughput is one event per VOICES+3 cycles (note-on) or VOICES+2 cycles (note-off).
- Duplicate note-on for a key already playing retriggers the same voice; no second voice is allocated.
- Velocity 0 note-on is treated as a note-on (no MIDI running-status conversion here).

Decomposition:
- Package synth_voice_pkg holds:
  - FSM state enum (IDLE, SCAN, SETUP, STROBE, OFFREL);
  - KEY_W = 7 and VEL_W = 8;
  - AGE_W default.
- One sub-module, voice_select: per-cycle candidate comparator.
  - Inputs: current index, active, key, age, running candidates.
  - Outputs: updated match/free/oldest candidates.
  - Keeps SCAN priority logic separate from the FSM.

Test Plan:
1. Reset, then note-on key 60 vel 100 -> reg_note_on high 10 cycles after accept; adr 0, vel 100; voice_gate = 8'b00000001; stole = 0.
2. Eight note-ons, keys 60..67 -> voices 0..7 in order. A ninth note-on, key 70 vel 50 -> adr 0 (oldest, age 7), stole = 1, and age[0] resets to 0.
3. Note-on key 62 while key 62 is active on voice 2 with vel 30 -> adr 2, vel 30, stole = 0, and voice_gate unchanged.
4. Note-off key 61 with key 61 on voice 1 -> voice_off pulse with voice_off_adr = 1, and gate bit 1 clears. Note-off key 99 (not playing) -> no voice_off, gates unchanged.
5. all_off and req_valid asserted together in IDLE -> voice_gate = 0 the next cycle, the request is not accepted, and it is accepted on the following IDLE cycle.
6. Assert reset_reg during SCAN of a note-on -> no reg_note_on. All outputs are 0 the next cycle, and req_ready is 1 after reset is released.
